// File: rtl/hazard_exc_ctrl_pkg.sv
// Shared pipeline-control definitions: timing widths, MDU latencies,
// eret sequencer states and CP0 exception codes.
package pipe_ctrl_pkg;

  // Width of the Tuse/Tnew timing fields carried down the pipe.
  localparam int TUSE_W = 2;

  // MDU occupancy after issue, in cycles.
  localparam int          MDU_CNT_W    = 4;
  localparam logic [3:0]  MDU_MULT_LAT = 4'd5;
  localparam logic [3:0]  MDU_DIV_LAT  = 4'd10;

  // eret sequencer states.
  typedef enum logic [1:0] {
    ERET_IDLE = 2'd0,
    ERET_HOLD = 2'd1,
    ERET_GO   = 2'd2
  } eret_state_e;

  // CP0 ExcCode values; 0 doubles as "no synchronous exception / interrupt".
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/hazard_exc_ctrl_if.sv
// Pipeline status in / stall-flush-redirect out bundle for the hazard and
// exception controller. master = pipeline side, slave = controller side.
interface hazard_exc_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [4:0]        d_rs;
  logic [4:0]        d_rt;
  logic              d_rs_used;
  logic              d_rt_used;
  logic [TUSE_W-1:0] d_rs_tuse;
  logic [TUSE_W-1:0] d_rt_tuse;
  logic [4:0]        e_dst;
  logic [4:0]        m_dst;
  logic [TUSE_W-1:0] e_tnew;
  logic [TUSE_W-1:0] m_tnew;
  logic              d_is_md;
  logic              e_md_start;
  logic              e_md_div;
  logic              d_is_eret;
  logic              e_mtc0_epc;
  logic              m_mtc0_epc;
  logic              m_valid;
  logic [4:0]        m_exc_code;
  logic              int_pending;

  logic              stall;
  logic              e_clr;
  logic              req;
  logic              eret_go;
  logic              md_busy;
  logic              in_handler;

  modport master (
    output d_rs, d_rt, d_rs_used, d_rt_used, d_rs_tuse, d_rt_tuse,
           e_dst, m_dst, e_tnew, m_tnew, d_is_md, e_md_start, e_md_div,
           d_is_eret, e_mtc0_epc, m_mtc0_epc, m_valid, m_exc_code, int_pending,
    input  stall, e_clr, req, eret_go, md_busy, in_handler
  );

  modport slave (
    input  d_rs, d_rt, d_rs_used, d_rt_used, d_rs_tuse, d_rt_tuse,
           e_dst, m_dst, e_tnew, m_tnew, d_is_md, e_md_start, e_md_div,
           d_is_eret, e_mtc0_epc, m_mtc0_epc, m_valid, m_exc_code, int_pending,
    output stall, e_clr, req, eret_go, md_busy, in_handler
  );

endinterface

// File: rtl/hazard_exc_ctrl_mdu_busy_counter.sv
// MDU occupancy down-counter: loaded with the mult/div latency on issue,
// counts down to zero, busy while non-zero.
module mdu_busy_counter
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_div,
  output logic o_busy
);

  logic [MDU_CNT_W-1:0] r_cnt;

  // Load on issue, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_div ? MDU_DIV_LAT : MDU_MULT_LAT;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_exc_ctrl.sv
// Hazard / exception controller: data-hazard and MDU stalls, eret
// sequencing around pending EPC writes, exception request and handler flag.
module hazard_exc_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  hazard_exc_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = ERET_IDLE;
  localparam logic [1:0] S_HOLD = ERET_HOLD;
  localparam logic [1:0] S_GO   = ERET_GO;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_in_handler;
  logic       w_hz_rs;
  logic       w_hz_rt;
  logic       w_req;
  logic       w_md_start;
  logic       w_cnt_busy;
  logic       w_md_busy;
  logic       w_hold;
  logic       w_stall;
  logic       w_eret_go;
  logic       w_epc_pending;

  // A source stalls when a younger-than-needed producer in E or M targets it.
  function automatic logic src_hazard(
    input logic              used,
    input logic [4:0]        src,
    input logic [TUSE_W-1:0] tuse,
    input logic [4:0]        edst,
    input logic [TUSE_W-1:0] etnew,
    input logic [4:0]        mdst,
    input logic [TUSE_W-1:0] mtnew
  );
    return used && (src != 5'd0) &&
           (((edst == src) && (etnew > tuse)) || ((mdst == src) && (mtnew > tuse)));
  endfunction

  assign w_hz_rs = src_hazard(bus.d_rs_used, bus.d_rs, bus.d_rs_tuse,
                              bus.e_dst, bus.e_tnew, bus.m_dst, bus.m_tnew);
  assign w_hz_rt = src_hazard(bus.d_rt_used, bus.d_rt, bus.d_rt_tuse,
                              bus.e_dst, bus.e_tnew, bus.m_dst, bus.m_tnew);

  // An interrupt is only taken outside the handler; sync exceptions always are.
  assign w_req = bus.m_valid &&
                 ((bus.m_exc_code != EXC_INT) || (bus.int_pending && !r_in_handler));

  // A flushed mult/div never reaches the MDU.
  assign w_md_start = bus.e_md_start && !w_req;

  mdu_busy_counter u_mdu (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_md_start),
    .i_div  (bus.e_md_div),
    .o_busy (w_cnt_busy)
  );

  assign w_md_busy     = w_cnt_busy || w_md_start;
  assign w_hold        = (r_state == S_HOLD);
  assign w_epc_pending = bus.e_mtc0_epc || bus.m_mtc0_epc;
  assign w_stall       = (w_hz_rs || w_hz_rt || (w_md_busy && bus.d_is_md) || w_hold) && !w_req;
  assign w_eret_go     = (r_state == S_GO) && !w_req;

  // eret waits in HOLD until no mtc0 to EPC is in flight, then redirects once.
  always_comb begin
    w_state_nxt = r_state;
    if (w_req) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.d_is_eret) w_state_nxt = w_epc_pending ? S_HOLD : S_GO;
        S_HOLD:  if (!w_epc_pending) w_state_nxt = S_GO;
        S_GO:    w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Handler flag: set on exception entry, cleared on eret; entry wins.
  always_ff @(posedge clk) begin
    if (reset)          r_in_handler <= 1'b0;
    else if (w_req)     r_in_handler <= 1'b1;
    else if (w_eret_go) r_in_handler <= 1'b0;
  end

  assign bus.stall      = w_stall;
  assign bus.e_clr      = w_stall;
  assign bus.req        = w_req;
  assign bus.eret_go    = w_eret_go;
  assign bus.md_busy    = w_md_busy;
  assign bus.in_handler = r_in_handler;

endmodule

// File: tb/tb_hazard_exc_ctrl.sv
// Directed + randomized bench for hazard_exc_ctrl with a behavioural model.
module tb_hazard_exc_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  hazard_exc_ctrl_if bus();

  hazard_exc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: cycles of MDU occupancy left, eret phase
  // ("idle", "hold", "go") and whether the core sits in a handler.
  int    mdl_mdu_left = 0;
  string mdl_phase    = "idle";
  bit    mdl_inh      = 1'b0;

  task automatic zero_inputs();
    bus.d_rs = '0;       bus.d_rt = '0;
    bus.d_rs_used = 0;   bus.d_rt_used = 0;
    bus.d_rs_tuse = '0;  bus.d_rt_tuse = '0;
    bus.e_dst = '0;      bus.m_dst = '0;
    bus.e_tnew = '0;     bus.m_tnew = '0;
    bus.d_is_md = 0;     bus.e_md_start = 0;   bus.e_md_div = 0;
    bus.d_is_eret = 0;   bus.e_mtc0_epc = 0;   bus.m_mtc0_epc = 0;
    bus.m_valid = 0;     bus.m_exc_code = '0;  bus.int_pending = 0;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Any used, non-zero source whose producer in E or M is not ready in time.
  function automatic bit hazard_ref();
    bit used[2];
    int src[2], tuse[2], dst[2], tnew[2];
    used = '{bus.d_rs_used, bus.d_rt_used};
    src  = '{int'(bus.d_rs), int'(bus.d_rt)};
    tuse = '{int'(bus.d_rs_tuse), int'(bus.d_rt_tuse)};
    dst  = '{int'(bus.e_dst), int'(bus.m_dst)};
    tnew = '{int'(bus.e_tnew), int'(bus.m_tnew)};
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 2; p++)
        if (used[s] && src[s] != 0 && dst[p] == src[s] && tnew[p] > tuse[s]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: compare all outputs at the falling edge, then advance the model.
  task automatic cycle(input string tag, input bit do_check);
    bit    e_req, e_start, e_busy, e_go, e_stall, epc;
    int    n_left;
    string n_phase;
    bit    n_inh;
    @(negedge clk);
    e_req   = bus.m_valid && (bus.m_exc_code != 0 || (bus.int_pending && !mdl_inh));
    e_start = bus.e_md_start && !e_req;
    e_busy  = (mdl_mdu_left > 0) || e_start;
    e_go    = (mdl_phase == "go") && !e_req;
    e_stall = (hazard_ref() || (e_busy && bus.d_is_md) || mdl_phase == "hold") && !e_req;
    if (do_check) begin
      check({tag, ".stall"},      bus.stall,      e_stall);
      check({tag, ".e_clr"},      bus.e_clr,      e_stall);
      check({tag, ".req"},        bus.req,        e_req);
      check({tag, ".eret_go"},    bus.eret_go,    e_go);
      check({tag, ".md_busy"},    bus.md_busy,    e_busy);
      check({tag, ".in_handler"}, bus.in_handler, mdl_inh);
    end
    epc = bus.e_mtc0_epc || bus.m_mtc0_epc;
    if (reset) begin
      n_left = 0; n_phase = "idle"; n_inh = 1'b0;
    end else begin
      n_left = e_start ? (bus.e_md_div ? 10 : 5) : (mdl_mdu_left > 0 ? mdl_mdu_left - 1 : 0);
      n_inh  = e_req ? 1'b1 : (e_go ? 1'b0 : mdl_inh);
      if (e_req)                                 n_phase = "idle";
      else if (mdl_phase == "go")                n_phase = "idle";
      else if (mdl_phase == "hold")              n_phase = epc ? "hold" : "go";
      else if (bus.d_is_eret)                    n_phase = epc ? "hold" : "go";
      else                                       n_phase = "idle";
    end
    @(posedge clk);
    #1;
    mdl_mdu_left = n_left;
    mdl_phase    = n_phase;
    mdl_inh      = n_inh;
  endtask

  initial begin
    logic [4:0] codes [4];
    codes = '{EXC_ADEL, EXC_ADES, EXC_RI, EXC_OV};

    // Reset with idle inputs
    zero_inputs();
    reset = 1'b1;
    cycle("rst0", 1'b0);
    cycle("rst1", 1'b0);
    reset = 1'b0;
    #1;
    check("post_rst.stall",   bus.stall,   1'b0);
    check("post_rst.e_clr",   bus.e_clr,   1'b0);
    check("post_rst.req",     bus.req,     1'b0);
    check("post_rst.eret_go", bus.eret_go, 1'b0);
    check("post_rst.md_busy", bus.md_busy, 1'b0);
    cycle("post_rst", 1'b1);

    // Load-use hazard from E, then the same with $zero as source
    bus.e_dst = 5'd5; bus.e_tnew = 2'd2; bus.d_rs = 5'd5; bus.d_rs_used = 1; bus.d_rs_tuse = 2'd0;
    #1;
    check("hz_e.stall", bus.stall, 1'b1);
    check("hz_e.e_clr", bus.e_clr, 1'b1);
    cycle("hz_e", 1'b1);
    bus.d_rs = 5'd0;
    #1;
    check("hz_zero.stall", bus.stall, 1'b0);
    cycle("hz_zero", 1'b1);
    zero_inputs();

    // div issue with an MDU instruction waiting in D
    bus.e_md_start = 1; bus.e_md_div = 1; bus.d_is_md = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("div_c%0d.md_busy", i), bus.md_busy, (i < 11) ? 1'b1 : 1'b0);
      check($sformatf("div_c%0d.stall", i),   bus.stall,   (i < 11) ? 1'b1 : 1'b0);
      cycle("div", 1'b1);
      bus.e_md_start = 0;
    end
    zero_inputs();

    // eret behind mtc0 EPC in E then M
    bus.d_is_eret = 1; bus.e_mtc0_epc = 1;
    #1; check("eret_c0.stall", bus.stall, 1'b0);
    cycle("eret_c0", 1'b1);
    bus.d_is_eret = 0; bus.e_mtc0_epc = 0; bus.m_mtc0_epc = 1;
    #1; check("eret_c1.stall", bus.stall, 1'b1);
    cycle("eret_c1", 1'b1);
    bus.m_mtc0_epc = 0;
    #1; check("eret_c2.stall", bus.stall, 1'b1); check("eret_c2.go", bus.eret_go, 1'b0);
    cycle("eret_c2", 1'b1);
    #1; check("eret_c3.stall", bus.stall, 1'b0); check("eret_c3.go", bus.eret_go, 1'b1);
    cycle("eret_c3", 1'b1);
    #1; check("eret_c4.go", bus.eret_go, 1'b0);
    cycle("eret_c4", 1'b1);

    // Overflow during a hazard stall, then interrupt masked by in_handler
    bus.e_dst = 5'd5; bus.e_tnew = 2'd2; bus.d_rs = 5'd5; bus.d_rs_used = 1;
    bus.m_valid = 1; bus.m_exc_code = EXC_OV;
    #1; check("ov.req", bus.req, 1'b1); check("ov.stall", bus.stall, 1'b0);
    cycle("ov", 1'b1);
    bus.m_exc_code = EXC_INT; bus.int_pending = 1;
    #1; check("ov_nx.in_handler", bus.in_handler, 1'b1); check("ov_nx.req", bus.req, 1'b0);
    cycle("ov_nx", 1'b1);
    bus.e_dst = 5'd0; bus.d_rs_used = 0; bus.d_is_eret = 1;
    #1; check("h_eret.req", bus.req, 1'b0);
    cycle("h_eret", 1'b1);
    bus.d_is_eret = 0;
    #1; check("h_go.eret_go", bus.eret_go, 1'b1); check("h_go.req", bus.req, 1'b0);
    cycle("h_go", 1'b1);
    #1; check("h_out.in_handler", bus.in_handler, 1'b0); check("h_out.req", bus.req, 1'b1);
    cycle("h_out", 1'b1);
    zero_inputs();
    cycle("h_idle", 1'b1);

    // Reset while the MDU counter reads 4
    bus.e_md_start = 1;
    cycle("mr_t0", 1'b1);
    bus.e_md_start = 0;
    cycle("mr_t1", 1'b1);
    reset = 1'b1;
    #1; check("mr_rst.md_busy", bus.md_busy, 1'b1);
    cycle("mr_rst", 1'b1);
    reset = 1'b0;
    #1; check("mr_after.md_busy", bus.md_busy, 1'b0);
    cycle("mr_after", 1'b1);

    // Reset in the middle of an eret HOLD
    bus.d_is_eret = 1; bus.e_mtc0_epc = 1;
    cycle("hr_t0", 1'b1);
    bus.d_is_eret = 0; reset = 1'b1;
    #1; check("hr_rst.stall", bus.stall, 1'b1);
    cycle("hr_rst", 1'b1);
    reset = 1'b0; bus.e_mtc0_epc = 0;
    #1; check("hr_after.stall", bus.stall, 1'b0);
    cycle("hr_after", 1'b1);
    #1; check("hr_after2.eret_go", bus.eret_go, 1'b0);
    cycle("hr_after2", 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      bus.d_rs        = 5'($urandom_range(0, 3));
      bus.d_rt        = 5'($urandom_range(0, 3));
      bus.d_rs_used   = ($urandom_range(0, 3) != 0);
      bus.d_rt_used   = ($urandom_range(0, 3) != 0);
      bus.d_rs_tuse   = 2'($urandom_range(0, 3));
      bus.d_rt_tuse   = 2'($urandom_range(0, 3));
      bus.e_dst       = 5'($urandom_range(0, 3));
      bus.m_dst       = 5'($urandom_range(0, 3));
      bus.e_tnew      = 2'($urandom_range(0, 3));
      bus.m_tnew      = 2'($urandom_range(0, 3));
      bus.d_is_md     = ($urandom_range(0, 3) == 0);
      bus.e_md_start  = ($urandom_range(0, 7) == 0);
      bus.e_md_div    = ($urandom_range(0, 1) == 0);
      bus.d_is_eret   = ($urandom_range(0, 7) == 0);
      bus.e_mtc0_epc  = ($urandom_range(0, 5) == 0);
      bus.m_mtc0_epc  = ($urandom_range(0, 5) == 0);
      bus.m_valid     = ($urandom_range(0, 1) == 0);
      bus.m_exc_code  = ($urandom_range(0, 9) == 0) ? codes[$urandom_range(0, 3)] : EXC_INT;
      bus.int_pending = ($urandom_range(0, 7) == 0);
      reset           = ($urandom_range(0, 49) == 0);
      cycle("rnd", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
